// File: rtl/day_counter.sv
`default_nettype none
// ============================================================================
// Module   : day_counter
// Purpose  : Day-of-week index (0=MON..6=SUN) advanced by the midnight tick,
//            with a button-driven SET mode; optional SET blink via DAY_BLINK_EN.
// Revision : 1.0
// ============================================================================
module day_counter #(
   parameter logic [2:0]  DEFAULT_DAY = 3'd0,
   parameter int unsigned BLINK_HALF  = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       day_tick,
   input  logic       set_btn,
   input  logic       up_btn,
   input  logic       down_btn,
   output logic [2:0] day,
   output logic       set_mode,
   output logic       blank
);

   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_SET = 1'b1
   } state_t;

   localparam int c_set = 0;
   localparam int c_up  = 1;
   localparam int c_dn  = 2;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_day;
   logic [2:0] w_day_nxt;
   logic [2:0] r_s0;
   logic [2:0] r_s1;
   logic [2:0] r_s2;
   logic [2:0] w_btn;
   logic [2:0] w_edge;

   // Button vectors are ordered {down, up, set}
   assign w_btn  = {down_btn, up_btn, set_btn};
   assign w_edge = r_s1 & ~r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0 <= '0;
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s0 <= w_btn;
         r_s1 <= r_s0;
         r_s2 <= r_s1;
      end
   end

   // An out-of-range 7 recovers to 0 on the next update in either direction
   function automatic logic [2:0] f_inc(input logic [2:0] d);
      return (d >= 3'd6) ? 3'd0 : d + 3'd1;
   endfunction

   function automatic logic [2:0] f_dec(input logic [2:0] d);
      logic [2:0] v;
      case (d)
         3'd0:    v = 3'd6;
         3'd7:    v = 3'd0;
         default: v = d - 3'd1;
      endcase
      return v;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_day_nxt   = r_day;
      case (r_state)
         ST_RUN: begin
            if (day_tick)
               w_day_nxt = f_inc(r_day);
            if (w_edge[c_set])
               w_state_nxt = ST_SET;
         end
         ST_SET: begin
            if (w_edge[c_set])
               w_state_nxt = ST_RUN;
            else if (w_edge[c_up] && !w_edge[c_dn])
               w_day_nxt = f_inc(r_day);
            else if (w_edge[c_dn] && !w_edge[c_up])
               w_day_nxt = f_dec(r_day);
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_day   <= DEFAULT_DAY;
      end else begin
         r_state <= w_state_nxt;
         r_day   <= w_day_nxt;
      end
   end

   assign day      = r_day;
   assign set_mode = (r_state == ST_SET);

`ifdef DAY_BLINK_EN
   localparam int c_cnt_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLINK_HALF - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               r_blank;
   logic               w_restart;

   // Entering, leaving or stepping the day restarts the phase so the new day shows at once
   assign w_restart = (r_state == ST_RUN) || (w_state_nxt == ST_RUN) ||
                      w_edge[c_up] || w_edge[c_dn];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_blank <= 1'b0;
      end else if (w_restart) begin
         r_cnt   <= '0;
         r_blank <= 1'b0;
      end else if (r_cnt == c_cnt_last) begin
         r_cnt   <= '0;
         r_blank <= ~r_blank;
      end else begin
         r_cnt   <= r_cnt + c_cnt_w'(1);
      end
   end

   assign blank = r_blank;
`else
   // No blink hardware; BLINK_HALF has no effect in this build
   assign blank = (BLINK_HALF == 0) ? 1'b0 : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_day_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_day_counter
// Purpose  : Directed stimulus for day_counter with a queued scoreboard and an
//            independent negedge monitor.
// Revision : 1.0
// ============================================================================
module tb_day_counter;

   localparam logic [2:0]  c_default_day = 3'd0;
   localparam int unsigned c_blink_half  = 4;
`ifdef DAY_BLINK_EN
   localparam bit c_blink = 1'b1;
`else
   localparam bit c_blink = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       day_tick;
   logic       set_btn;
   logic       up_btn;
   logic       down_btn;
   logic [2:0] day;
   logic       set_mode;
   logic       blank;

   typedef struct {
      int         due;
      bit         is_async;
      logic [2:0] d;
      logic       sm;
      logic       bl;
      bit         care_bl;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   n_vec      = 0;
   int   n_err      = 0;
   int   cyc        = 0;
   bit   async_pend = 1'b0;
   int   c0;
   event ev_async;

   day_counter #(
      .DEFAULT_DAY (c_default_day),
      .BLINK_HALF  (c_blink_half)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .day_tick (day_tick),
      .set_btn  (set_btn),
      .up_btn   (up_btn),
      .down_btn (down_btn),
      .day      (day),
      .set_mode (set_mode),
      .blank    (blank)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, want < 50000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input exp_t e);
      n_vec++;
      if (day !== e.d || set_mode !== e.sm || (e.care_bl && blank !== e.bl)) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got day=%0d set_mode=%0b blank=%0b, want day=%0d set_mode=%0b blank=%0b",
                  e.nm, cyc, day, set_mode, blank, e.d, e.sm, e.bl);
      end
   endtask

   // Monitor: compares every entry whose due cycle has arrived, or an async entry on request
   always begin
      @(negedge clk or ev_async);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].is_async ? async_pend : (sb[i].due == cyc)) begin
            check(sb[i]);
            sb.delete(i);
         end
      end
      async_pend = 1'b0;
   end

   function automatic bit care_for(input logic sm);
      return !(c_blink && sm);
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push(input int due, input logic [2:0] d, input logic sm,
                       input logic bl, input bit care_bl, input string nm);
      exp_t e;
      e.due = due; e.is_async = 1'b0; e.d = d; e.sm = sm;
      e.bl = bl; e.care_bl = care_bl; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic tick(input logic [2:0] d, input logic sm, input string nm);
      day_tick = 1'b1;
      push(cyc + 1, d, sm, 1'b0, care_for(sm), nm);
      step();
      day_tick = 1'b0;
   endtask

   // btns = {down, up, set}; action lands three edges after the driving negedge
   task automatic press(input logic [2:0] btns, input logic [2:0] d, input logic sm,
                        input string nm);
      {down_btn, up_btn, set_btn} = btns;
      push(cyc + 3, d, sm, 1'b0, care_for(sm), nm);
      repeat (3) step();
      {down_btn, up_btn, set_btn} = 3'b000;
      repeat (2) step();
   endtask

   initial begin
      rst_n = 1'b0; day_tick = 1'b0; set_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
      step();
      push(cyc + 1, 3'd0, 1'b0, 1'b0, 1'b1, "in_reset");
      repeat (2) step();
      rst_n = 1'b1;
      push(cyc + 1, 3'd0, 1'b0, 1'b0, 1'b1, "reset_release");
      push(cyc + 4, 3'd0, 1'b0, 1'b0, 1'b1, "idle_after_reset");
      repeat (5) step();

      // Ticks: 0 -> 5, then a full week with 6 -> 0 wrap
      tick(3'd1, 1'b0, "tick_1"); tick(3'd2, 1'b0, "tick_2"); tick(3'd3, 1'b0, "tick_3");
      tick(3'd4, 1'b0, "tick_4"); tick(3'd5, 1'b0, "tick_5");
      tick(3'd6, 1'b0, "week_6"); tick(3'd0, 1'b0, "week_wrap_0"); tick(3'd1, 1'b0, "week_1");
      tick(3'd2, 1'b0, "week_2"); tick(3'd3, 1'b0, "week_3"); tick(3'd4, 1'b0, "week_4");
      tick(3'd5, 1'b0, "week_5");
      step();

      // SET editing with both wraps
      press(3'b001, 3'd5, 1'b1, "enter_set");
      press(3'b010, 3'd6, 1'b1, "up_6");
      press(3'b010, 3'd0, 1'b1, "up_wrap_0");
      press(3'b010, 3'd1, 1'b1, "up_1");
      press(3'b100, 3'd0, 1'b1, "down_0");
      press(3'b100, 3'd6, 1'b1, "down_wrap_6");
      press(3'b001, 3'd6, 1'b0, "exit_set");
      press(3'b010, 3'd6, 1'b0, "run_ignores_up");
      press(3'b100, 3'd6, 1'b0, "run_ignores_down");

      // SET ignores ticks, simultaneous up/down, and long holds
      press(3'b001, 3'd6, 1'b1, "enter_set_2");
      tick(3'd6, 1'b1, "set_drops_tick");
      push(cyc + 2, 3'd6, 1'b1, 1'b0, care_for(1'b1), "tick_not_queued");
      step(); step();
      press(3'b110, 3'd6, 1'b1, "up_down_same");
      up_btn = 1'b1;
      push(cyc + 3,   3'd0, 1'b1, 1'b0, care_for(1'b1), "hold_up_first");
      push(cyc + 50,  3'd0, 1'b1, 1'b0, care_for(1'b1), "hold_up_mid");
      push(cyc + 100, 3'd0, 1'b1, 1'b0, care_for(1'b1), "hold_up_end");
      repeat (100) step();
      up_btn = 1'b0;
      repeat (3) step();
      press(3'b010, 3'd1, 1'b1, "up_to_1");
      press(3'b010, 3'd2, 1'b1, "up_to_2");
      press(3'b010, 3'd3, 1'b1, "up_to_3");
      press(3'b010, 3'd4, 1'b1, "up_to_4");

      // Asynchronous reset mid-SET, checked between clock edges
      #2 rst_n = 1'b0;
      #1;
      begin
         exp_t e;
         e.due = cyc; e.is_async = 1'b1; e.d = c_default_day; e.sm = 1'b0;
         e.bl = 1'b0; e.care_bl = 1'b1; e.nm = "async_reset";
         sb.push_back(e);
      end
      async_pend = 1'b1;
      -> ev_async;
      repeat (2) step();
      rst_n = 1'b1;
      push(cyc + 1, 3'd0, 1'b0, 1'b0, 1'b1, "post_async_reset");
      repeat (3) step();

      // Tick and set edge on the same edge: advance and enter SET
      set_btn = 1'b1;
      push(cyc + 3, 3'd1, 1'b1, 1'b0, care_for(1'b1), "tick_and_set");
      step(); step();
      day_tick = 1'b1;
      step();
      day_tick = 1'b0; set_btn = 1'b0;
      repeat (2) step();
      press(3'b011, 3'd1, 1'b0, "set_up_same_exit");

`ifdef DAY_BLINK_EN
      // Entry at c0+3; blank toggles every 4 edges; up edge restarts the phase
      c0 = cyc;
      press(3'b001, 3'd1, 1'b1, "blink_enter");
      push(c0 + 6,  3'd1, 1'b1, 1'b0, 1'b1, "blink_phase0_end");
      push(c0 + 7,  3'd1, 1'b1, 1'b1, 1'b1, "blink_toggle_1");
      push(c0 + 10, 3'd1, 1'b1, 1'b1, 1'b1, "blink_phase1_end");
      push(c0 + 11, 3'd1, 1'b1, 1'b0, 1'b1, "blink_toggle_0");
      push(c0 + 15, 3'd1, 1'b1, 1'b1, 1'b1, "blink_before_up");
      push(c0 + 16, 3'd2, 1'b1, 1'b0, 1'b1, "blink_up_forces_0");
      repeat (8) step();
      press(3'b010, 3'd2, 1'b1, "blink_up");
      push(c0 + 19, 3'd2, 1'b1, 1'b0, 1'b1, "blink_restart_hold");
      push(c0 + 20, 3'd2, 1'b1, 1'b1, 1'b1, "blink_restart_toggle");
      repeat (2) step();
      press(3'b001, 3'd2, 1'b0, "blink_exit");
      push(c0 + 26, 3'd2, 1'b0, 1'b0, 1'b1, "blink_run_low_a");
      push(c0 + 30, 3'd2, 1'b0, 1'b0, 1'b1, "blink_run_low_b");
      repeat (8) step();
`endif

      repeat (5) step();
      foreach (sb[i]) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got no comparison, want one at cycle %0d", sb[i].nm, sb[i].due);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
